binary_encoder: RTL and testbench

BINARY_ENCODER -- requirements
Module: binary_encoder

---
 rtl/binary_encoder.sv | 92 +++++++++
 tb/tb_binary_encoder.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/binary_encoder.sv
// Sticky 16-request pending register drained one index per cycle through a valid/ready port.
// Define ROUND_ROBIN_EN for rotating priority; otherwise the lowest set index wins.
module binary_encoder (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] encoder_input,
  input  logic        load_enable,
  input  logic        encoder_ready,
  output logic [3:0]  encoder_output,
  output logic        encoder_valid,
  output logic [15:0] pending_output
);

  typedef enum logic {IDLE = 1'b0, PRESENT = 1'b1} state_t;

  state_t      state_q, state_d;
  logic [15:0] pend_q, pend_d;
  logic [15:0] clr;
  logic [3:0]  idx_q, idx_d;
  logic        sel_found;
  logic [3:0]  sel_idx;
  logic        take;

  // Index i lives in bit 15-i, so the lowest index is the highest set bit.
  function automatic logic [4:0] pick_fixed(input logic [15:0] p);
    logic [4:0] r;
    r = '0;
    for (int b = 0; b < 16; b++) begin
      if (p[b]) r = {1'b1, 4'(15 - b)};
    end
    return r;
  endfunction

`ifdef ROUND_ROBIN_EN
  logic [3:0] ptr_q;

  // Scan backwards so the candidate nearest to last+1 is written last.
  function automatic logic [4:0] pick_rr(input logic [15:0] p, input logic [3:0] last);
    logic [4:0] r;
    logic [3:0] idx;
    r = '0;
    for (int k = 16; k >= 1; k--) begin
      idx = last + 4'(k);
      if (p[4'd15 - idx]) r = {1'b1, idx};
    end
    return r;
  endfunction

  always_comb {sel_found, sel_idx} = pick_rr(pend_q, ptr_q);
`else
  always_comb {sel_found, sel_idx} = pick_fixed(pend_q);
`endif

  always_comb begin
    take    = sel_found && ((state_q == IDLE) || encoder_ready);
    state_d = state_q;
    idx_d   = idx_q;
    clr     = '0;
    if (take) begin
      clr     = 16'h8000 >> sel_idx;
      idx_d   = sel_idx;
      state_d = PRESENT;
    end else if ((state_q == PRESENT) && encoder_ready) begin
      state_d = IDLE;
    end
    // Merge after clearing so a same-edge re-request keeps its bit.
    pend_d = (pend_q & ~clr) | (load_enable ? encoder_input : 16'h0000);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      pend_q  <= '0;
      idx_q   <= '0;
`ifdef ROUND_ROBIN_EN
      ptr_q   <= 4'd15;
`endif
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      idx_q   <= idx_d;
`ifdef ROUND_ROBIN_EN
      if (take) ptr_q <= sel_idx;
`endif
    end
  end

  assign encoder_output = idx_q;
  assign encoder_valid  = (state_q == PRESENT);
  assign pending_output = pend_q;

endmodule

// File: tb/tb_binary_encoder.sv
// Directed bench for binary_encoder: expected indices are queued as requests are loaded
// and popped as each transfer appears on the output port.
module tb_binary_encoder;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] encoder_input;
  logic        load_enable;
  logic        encoder_ready;
  logic [3:0]  encoder_output;
  logic        encoder_valid;
  logic [15:0] pending_output;

  int n_checks = 0;
  int n_errors = 0;
  int sb[$];

  binary_encoder dut (
    .clk            (clk),
    .reset          (reset),
    .encoder_input  (encoder_input),
    .load_enable    (load_enable),
    .encoder_ready  (encoder_ready),
    .encoder_output (encoder_output),
    .encoder_valid  (encoder_valid),
    .pending_output (pending_output)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [15:0] req);
    encoder_input = req;
    load_enable   = 1'b1;
    tick();
    load_enable   = 1'b0;
    encoder_input = '0;
  endtask

  // With encoder_ready high, every valid cycle is a transfer of the queue head.
  task automatic drain(input string tag);
    int budget;
    int exp;
    budget = 8;
    while (!encoder_valid && budget > 0) begin
      tick();
      budget--;
    end
    if (!encoder_valid) check({tag, "_timeout"}, 32'(encoder_valid), 32'd1);
    while (sb.size() > 0) begin
      exp = sb.pop_front();
      check({tag, "_vld"}, 32'(encoder_valid), 32'd1);
      check({tag, "_idx"}, 32'(encoder_output), 32'(exp));
      tick();
    end
    check({tag, "_end"}, 32'(encoder_valid), 32'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; encoder_input = '0; load_enable = 1'b0; encoder_ready = 1'b0;
    do_reset();
    check("rst_vld", 32'(encoder_valid), 32'd0);
    check("rst_idx", 32'(encoder_output), 32'd0);
    check("rst_pend", 32'(pending_output), 32'd0);

    // Single request, one-cycle latency after capture.
    encoder_ready = 1'b1;
    load(16'h8000);
    check("s1_vld0", 32'(encoder_valid), 32'd0);
    check("s1_pend0", 32'(pending_output), 32'h8000);
    tick();
    check("s1_vld1", 32'(encoder_valid), 32'd1);
    check("s1_idx1", 32'(encoder_output), 32'd0);
    check("s1_pend1", 32'(pending_output), 32'd0);
    tick();
    check("s1_vld2", 32'(encoder_valid), 32'd0);
    check("s1_idx2", 32'(encoder_output), 32'd0);
    check("s1_pend2", 32'(pending_output), 32'd0);

    // All sixteen requests back to back.
    do_reset();
    encoder_ready = 1'b1;
    for (int i = 0; i < 16; i++) sb.push_back(i);
    load(16'hFFFF);
    drain("ffff");

    // Stall then release.
    encoder_ready = 1'b0;
    load(16'h0401);
    tick();
    for (int i = 0; i < 5; i++) begin
      check("s3_hold_vld", 32'(encoder_valid), 32'd1);
      check("s3_hold_idx", 32'(encoder_output), 32'd5);
      check("s3_hold_pend", 32'(pending_output), 32'h0001);
      tick();
    end
    encoder_ready = 1'b1;
    sb.push_back(5); sb.push_back(15);
    drain("s3");

    // Same bit selected and re-loaded on one edge stays pending.
    encoder_ready = 1'b0;
    load(16'h0400);
    load(16'h0400);
    check("setwin_pend", 32'(pending_output), 32'h0400);
    check("setwin_idx", 32'(encoder_output), 32'd5);
    check("setwin_vld", 32'(encoder_valid), 32'd1);
    encoder_ready = 1'b1;
    sb.push_back(5); sb.push_back(5);
    drain("setwin");
    check("setwin_pend_end", 32'(pending_output), 32'd0);

    // Re-request the index currently on the output.
    do_reset();
    encoder_ready = 1'b0;
    load(16'h1040);
    tick();
    check("rereq_first", 32'(encoder_output), 32'd3);
    load(16'h4000);
    check("rereq_pend0", 32'(pending_output), 32'h4040);
    check("rereq_hold", 32'(encoder_output), 32'd3);
    encoder_ready = 1'b1;
    load(16'h1000);
    check("rereq_bit12", 32'(pending_output[12]), 32'd1);
`ifdef ROUND_ROBIN_EN
    check("rereq_pend1", 32'(pending_output), 32'h5000);
    sb.push_back(9); sb.push_back(1); sb.push_back(3);
`else
    check("rereq_pend1", 32'(pending_output), 32'h1040);
    sb.push_back(1); sb.push_back(3); sb.push_back(9);
`endif
    drain("rereq");

    // Policy: last grant 14, then last grant 0.
    encoder_ready = 1'b1;
    sb.push_back(14);
    load(16'h0002);
    drain("rr_g14");
    sb.push_back(0); sb.push_back(14);
    load(16'h8002);
    drain("rr_after14");
    sb.push_back(0);
    load(16'h8000);
    drain("rr_g0");
`ifdef ROUND_ROBIN_EN
    sb.push_back(14); sb.push_back(0);
`else
    sb.push_back(0); sb.push_back(14);
`endif
    load(16'h8002);
    drain("rr_after0");

    // Reset while presenting, with handshake and load active.
    encoder_ready = 1'b0;
    load(16'h01F0);
    tick();
    check("rst2_pre_vld", 32'(encoder_valid), 32'd1);
    check("rst2_pre_idx", 32'(encoder_output), 32'd7);
    check("rst2_pre_pend", 32'(pending_output), 32'h00F0);
    reset = 1'b1; encoder_input = 16'hFFFF; load_enable = 1'b1; encoder_ready = 1'b1;
    tick();
    reset = 1'b0; encoder_input = '0; load_enable = 1'b0;
    check("rst2_vld", 32'(encoder_valid), 32'd0);
    check("rst2_pend", 32'(pending_output), 32'd0);
    check("rst2_idx", 32'(encoder_output), 32'd0);
    for (int i = 0; i < 3; i++) tick();
    check("rst2_quiet_vld", 32'(encoder_valid), 32'd0);
    check("rst2_quiet_pend", 32'(pending_output), 32'd0);
    sb.push_back(0); sb.push_back(15);
    load(16'h8001);
    drain("post_rst");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, errors=%0d checks=%0d", n_errors, n_checks);
    $fatal(1);
  end

endmodule
